// File: rtl/i2c_slave.sv
// I2C target (7-bit address): byte writes into rx_data, byte reads from tx_data.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave #(
    parameter logic [6:0]  ADDRESS     = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_tick,
    output logic       tx_req,
    output logic       master_ack,
    output logic       addressed,
    output logic       rw,
    output logic       stop_tick
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    state_t     state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic       scl_raw, sda_raw, scl_s, sda_s, scl_d, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       sda_oe, ack_drv, load_pend, rd_first;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
        end
    end

    assign scl_raw = scl_sync[SYNC_STAGES-1];
    assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_hist <= '1;
            sda_hist <= '1;
        end else begin
            scl_hist <= {scl_hist[0], scl_raw};
            sda_hist <= {sda_hist[0], sda_raw};
        end
    end

    assign scl_s = (scl_raw & scl_hist[0]) | (scl_raw & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
    assign sda_s = (sda_raw & sda_hist[0]) | (sda_raw & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
`else
    assign scl_s = scl_raw;
    assign sda_s = sda_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end

    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            sda_oe     <= 1'b0;
            ack_drv    <= 1'b0;
            load_pend  <= 1'b0;
            rd_first   <= 1'b0;
            rx_data    <= '0;
            rx_tick    <= 1'b0;
            tx_req     <= 1'b0;
            master_ack <= 1'b1;
            addressed  <= 1'b0;
            rw         <= 1'b0;
            stop_tick  <= 1'b0;
        end else begin
            rx_tick   <= 1'b0;
            tx_req    <= 1'b0;
            stop_tick <= 1'b0;

            // tx_data is captured in the tx_req cycle; after an address ACK the
            // fall has already happened, so the MSB goes out right away.
            if (load_pend) begin
                load_pend <= 1'b0;
                shift     <= tx_data;
                if (!rd_first)
                    sda_oe <= ~tx_data[7];
            end

            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_drv   <= 1'b0;
                load_pend <= 1'b0;
                addressed <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                ack_drv   <= 1'b0;
                load_pend <= 1'b0;
                addressed <= 1'b0;
                stop_tick <= 1'b1;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shift[6:0] == ADDRESS) begin
                                state     <= ADDR_ACK;
                                rw        <= sda_s;
                                addressed <= 1'b1;
                                ack_drv   <= 1'b0;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, WRITE_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_oe  <= 1'b1;
                            ack_drv <= 1'b1;
                        end else begin
                            ack_drv <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == WRITE_ACK || !rw) begin
                                state <= WRITE;
                            end else begin
                                state     <= READ;
                                tx_req    <= 1'b1;
                                load_pend <= 1'b1;
                                rd_first  <= 1'b0;
                            end
                        end
                    end
                    WRITE: if (scl_rise) begin
                        shift   <= {shift[6:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data <= {shift[6:0], sda_s};
                            rx_tick <= 1'b1;
                            ack_drv <= 1'b0;
                            state   <= WRITE_ACK;
                        end
                    end
                    READ: if (scl_fall) begin
                        if (rd_first) begin
                            rd_first <= 1'b0;
                            sda_oe   <= ~shift[7];
                        end else if (bit_cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= READ_ACK;
                        end else begin
                            shift   <= {shift[6:0], 1'b0};
                            sda_oe  <= ~shift[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    // Next byte is loaded during SCL high but only driven after the following fall.
                    READ_ACK: if (scl_rise) begin
                        master_ack <= sda_s;
                        if (!sda_s) begin
                            state     <= READ;
                            tx_req    <= 1'b1;
                            load_pend <= 1'b1;
                            rd_first  <= 1'b1;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master on a pulled-up SDA line.
module tb_i2c_slave;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_drv_low;
    logic [7:0] tx_data;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic       rx_tick, tx_req, master_ack, addressed, rw, stop_tick;

    int tests = 0;
    int fails = 0;
    int n_rx = 0, n_tx = 0, n_stop = 0;
    logic mon_en = 1'b0;
    logic dut_drove = 1'b0;

    assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(rst_n), .SCL(scl), .SDA(sda_bus), .tx_data(tx_data),
        .rx_data(rx_data), .rx_tick(rx_tick), .tx_req(tx_req), .master_ack(master_ack),
        .addressed(addressed), .rw(rw), .stop_tick(stop_tick)
    );

    always @(negedge clk) begin
        if (rx_tick)   n_rx++;
        if (tx_req)    n_tx++;
        if (stop_tick) n_stop++;
        if (mon_en && !sda_drv_low && sda_bus === 1'b0) dut_drove = 1'b1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        sda_drv_low = 1'b0; waitq();
        scl = 1'b1;         waitq();
        sda_drv_low = 1'b1; waitq();
        scl = 1'b0;         waitq();
    endtask

    task automatic m_stop();
        sda_drv_low = 1'b1; waitq();
        scl = 1'b1;         waitq();
        sda_drv_low = 1'b0; waitq();
    endtask

    task automatic write_bit(input logic b);
        sda_drv_low = ~b; waitq();
        scl = 1'b1;       waitq(); waitq();
        scl = 1'b0;       waitq();
    endtask

    task automatic write_bit_glitch(input logic b);
        sda_drv_low = ~b; waitq();
        scl = 1'b1;       waitq();
        scl = 1'b0;       @(negedge clk);
        scl = 1'b1;       waitq();
        scl = 1'b0;       waitq();
    endtask

    task automatic read_bit(output logic b);
        sda_drv_low = 1'b0; waitq();
        scl = 1'b1;         waitq();
        b = sda_bus;        waitq();
        scl = 1'b0;         waitq();
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] glitch_byte;

        rst_n = 1'b0; scl = 1'b1; sda_drv_low = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda",        sda_bus,    1'b1);
        check("rst_rx_data",    rx_data,    8'h00);
        check("rst_rx_tick",    rx_tick,    1'b0);
        check("rst_tx_req",     tx_req,     1'b0);
        check("rst_master_ack", master_ack, 1'b1);
        check("rst_addressed",  addressed,  1'b0);
        check("rst_rw",         rw,         1'b0);
        check("rst_stop_tick",  stop_tick,  1'b0);
        rst_n = 1'b1;
        waitq();

        // Write 0xA5 to own address
        m_start();
        write_byte(8'hA0);
        read_bit(ack);
        check("w_addr_ack",  ack,       1'b0);
        check("w_addressed", addressed, 1'b1);
        check("w_rw",        rw,        1'b0);
        write_byte(8'hA5);
        read_bit(ack);
        check("w_data_ack",  ack,       1'b0);
        check("w_rx_data",   rx_data,   8'hA5);
        check("w_rx_ticks",  n_rx,      1);
        m_stop();
        waitq();
        check("w_stop_ticks", n_stop,   1);
        check("w_idle_addr",  addressed, 1'b0);
        check("w_sda_rel",    sda_bus,  1'b1);

        // Foreign address 0x51: never acknowledged
        mon_en = 1'b1;
        m_start();
        write_byte(8'hA2);
        read_bit(ack);
        check("nx_addr_ack",  ack,       1'b1);
        check("nx_addressed", addressed, 1'b0);
        write_byte(8'h3C);
        read_bit(ack);
        check("nx_data_ack",  ack,       1'b1);
        m_stop();
        waitq();
        mon_en = 1'b0;
        check("nx_drove",     dut_drove, 1'b0);
        check("nx_rx_ticks",  n_rx,      1);
        check("nx_rx_data",   rx_data,   8'hA5);
        check("nx_stops",     n_stop,    2);

        // Read one byte, master NACKs
        tx_data = 8'h45;
        m_start();
        write_byte(8'hA1);
        read_bit(ack);
        check("r_addr_ack",  ack,       1'b0);
        check("r_rw",        rw,        1'b1);
        check("r_addressed", addressed, 1'b1);
        read_byte(rd);
        check("r_data",      rd,        8'b0100_0101);
        write_bit(1'b1);
        check("r_master_ack", master_ack, 1'b1);
        check("r_tx_reqs",    n_tx,       1);
        m_stop();
        waitq();
        check("r_sda_rel",    sda_bus,   1'b1);
        check("r_idle_addr",  addressed, 1'b0);

        // Partial write, repeated START, two-byte read
        m_start();
        write_byte(8'hA0);
        read_bit(ack);
        check("rs_w_ack", ack, 1'b0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        tx_data = 8'h9C;
        m_start();
        write_byte(8'hA1);
        read_bit(ack);
        check("rs_r_ack",    ack,  1'b0);
        check("rs_rw",       rw,   1'b1);
        check("rs_rx_ticks", n_rx, 1);
        read_byte(rd);
        check("rs_byte0",    rd,   8'h9C);
        tx_data = 8'h3A;
        write_bit(1'b0);
        check("rs_mack0",    master_ack, 1'b0);
        read_byte(rd);
        check("rs_byte1",    rd,   8'h3A);
        write_bit(1'b1);
        check("rs_mack1",    master_ack, 1'b1);
        check("rs_tx_reqs",  n_tx, 3);
        m_stop();
        waitq();

        // Reset asserted in the middle of a read byte
        tx_data = 8'h00;
        m_start();
        write_byte(8'hA1);
        read_bit(ack);
        check("mr_addr_ack", ack, 1'b0);
        rd = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            read_bit(ack);
            rd[i] = ack;
        end
        check("mr_bits",     rd,      8'hF8);
        check("mr_driving",  sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_sda_rel",    sda_bus,    1'b1);
        check("mr_rx_data",    rx_data,    8'h00);
        check("mr_tx_req",     tx_req,     1'b0);
        check("mr_master_ack", master_ack, 1'b1);
        check("mr_addressed",  addressed,  1'b0);
        check("mr_rw",         rw,         1'b0);
        check("mr_stop_tick",  stop_tick,  1'b0);
        check("mr_rx_tick",    rx_tick,    1'b0);
        waitq();
        rst_n = 1'b1;
        write_byte(8'hA0);
        read_bit(ack);
        check("mr_no_start_ack", ack, 1'b1);
        m_stop();
        m_start();
        write_byte(8'hA0);
        read_bit(ack);
        check("mr_fresh_ack", ack, 1'b0);
        write_byte(8'h5A);
        read_bit(ack);
        check("mr_fresh_data_ack", ack, 1'b0);
        check("mr_fresh_rx",  rx_data, 8'h5A);
        m_stop();
        waitq();
        check("mr_rx_ticks",  n_rx,   2);
        check("mr_stops",     n_stop, 6);

        // One-clk low glitch on SCL during a data bit
        m_start();
        write_byte(8'hA0);
        read_bit(ack);
        check("g_addr_ack", ack, 1'b0);
        glitch_byte = 8'hB2;
        write_bit_glitch(glitch_byte[7]);
        for (int i = 6; i >= 1; i--) write_bit(glitch_byte[i]);
        waitq();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        check("g_rx_ticks", n_rx,    2);
        check("g_rx_data",  rx_data, 8'h5A);
`else
        check("g_rx_ticks", n_rx,    3);
        check("g_rx_data",  rx_data, 8'hD9);
`endif
        rst_n = 1'b0;
        sda_drv_low = 1'b0;
        #1;
        check("g_rst_sda", sda_bus, 1'b1);
        waitq();
        rst_n = 1'b1;
        waitq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
